pwm_multi: RTL and testbench

- N-channel PWM generator sharing one programmable-period counter. Successor to the fixed 2^R-period single-channel PWM.
- Adds:
  - programmable period;
  - edge- or center-aligned counting;
  - per-channel duty;
  - glitch-free double-buffered updates that commit only at a period boundary.
- Sits between a register/control interface and the pads or gate drivers.

---
 rtl/pwm_multi.sv | 108 ++++++++++
 tb/tb_pwm_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one programmable-period counter, edge- or center-aligned.
// Period, duty and alignment are double-buffered and commit only at a period boundary.
module pwm_multi #(
    parameter int R = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           load,
    input  logic [R-1:0]   period,
    input  logic [N*R-1:0] duty,
    input  logic           center,
    output logic [N-1:0]   pwm_out,
    output logic           period_tick,
    output logic           pending
);

    localparam logic [R-1:0] ONE = R'(1);

    logic [R-1:0]   cnt_reg, cnt_next;
    logic           dir_reg, dir_next;      // 0 = counting up, 1 = counting down
    logic [R-1:0]   stg_period_reg;
    logic [N*R-1:0] stg_duty_reg;
    logic           stg_center_reg;
    logic [R-1:0]   act_period_reg;
    logic [N*R-1:0] act_duty_reg;
    logic           act_center_reg;
    logic           pending_reg;
    logic [N-1:0]   pwm_reg, pwm_next;
    logic           tick_reg, tick_next;

    logic running;
    logic last_cycle;
    logic boundary;
    logic commit;

    assign running    = en && (act_period_reg != '0);
    assign last_cycle = act_center_reg ? ((cnt_reg == '0) && dir_reg)
                                       : (cnt_reg == act_period_reg - ONE);
    assign boundary   = running && last_cycle;
    // A stalled or zero-period counter has no boundary to wait for, so staged values apply at once.
    assign commit     = pending_reg && (!en || (act_period_reg == '0) || boundary);

    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        if (commit || !running) begin
            cnt_next = '0;
            dir_next = 1'b0;
        end else if (!act_center_reg) begin
            cnt_next = (cnt_reg == act_period_reg - ONE) ? '0 : cnt_reg + ONE;
        end else if (!dir_reg) begin
            // Turnaround cycles hold the count so each extreme is seen twice.
            if (cnt_reg == act_period_reg - ONE) dir_next = 1'b1;
            else                                 cnt_next = cnt_reg + ONE;
        end else begin
            if (cnt_reg == '0) dir_next = 1'b0;
            else               cnt_next = cnt_reg - ONE;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cmp
            assign pwm_next[gi] = running && (cnt_reg < act_duty_reg[gi*R +: R]);
        end
    endgenerate

    assign tick_next = running && (cnt_reg == '0) && !dir_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            dir_reg        <= 1'b0;
            stg_period_reg <= '0;
            stg_duty_reg   <= '0;
            stg_center_reg <= 1'b0;
            act_period_reg <= '0;
            act_duty_reg   <= '0;
            act_center_reg <= 1'b0;
            pending_reg    <= 1'b0;
            pwm_reg        <= '0;
            tick_reg       <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            dir_reg  <= dir_next;
            pwm_reg  <= pwm_next;
            tick_reg <= tick_next;
            // Commit reads the old staging contents even when a load lands on the same edge.
            if (commit) begin
                act_period_reg <= stg_period_reg;
                act_duty_reg   <= stg_duty_reg;
                act_center_reg <= stg_center_reg;
            end
            if (load) begin
                stg_period_reg <= period;
                stg_duty_reg   <= duty;
                stg_center_reg <= center;
            end
            pending_reg <= load || (pending_reg && !commit);
        end
    end

    assign pwm_out     = pwm_reg;
    assign period_tick = tick_reg;
    assign pending     = pending_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized and directed bench for pwm_multi against a position-in-period reference model.
module tb_pwm_multi;

    localparam int R = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           en;
    logic           load;
    logic [R-1:0]   period;
    logic [N*R-1:0] duty;
    logic           center;
    logic [N-1:0]   pwm_out;
    logic           period_tick;
    logic           pending;

    pwm_multi #(.R(R), .N(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .load        (load),
        .period      (period),
        .duty        (duty),
        .center      (center),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: configuration plus position t within the current period.
    int m_ap, m_sp, m_t;
    int m_ad [N];
    int m_sd [N];
    bit m_ac, m_sc, m_pend;
    logic [N-1:0] exp_pwm;
    logic         exp_tick, exp_pend;
    int hi0, hi1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_ap = 0; m_sp = 0; m_t = 0; m_ac = 0; m_sc = 0; m_pend = 0;
        for (int i = 0; i < N; i++) begin
            m_ad[i] = 0;
            m_sd[i] = 0;
        end
        exp_pwm = '0; exp_tick = 1'b0; exp_pend = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit l, input int p, input logic [N*R-1:0] d, input bit c);
        int  len, pos;
        bit  run, cmt;
        len = m_ac ? 2 * m_ap : m_ap;
        run = e && (m_ap != 0);
        pos = (m_ac && m_t >= m_ap) ? (2 * m_ap - 1 - m_t) : m_t;
        for (int i = 0; i < N; i++) exp_pwm[i] = run && (pos < m_ad[i]);
        exp_tick = run && (m_t == 0);
        cmt = m_pend && (!e || m_ap == 0 || (run && m_t == len - 1));
        if (cmt || !run) m_t = 0;
        else             m_t = (m_t + 1) % len;
        if (cmt) begin
            m_ap = m_sp; m_ac = m_sc;
            for (int i = 0; i < N; i++) m_ad[i] = m_sd[i];
        end
        if (l) begin
            m_sp = p; m_sc = c; m_pend = 1;
            for (int i = 0; i < N; i++) m_sd[i] = int'(d[i*R +: R]);
        end else if (cmt) begin
            m_pend = 0;
        end
        exp_pend = m_pend;
    endtask

    // Check what the last edge produced, then drive the inputs for the next edge.
    task automatic step(input logic e, input logic l, input logic [R-1:0] p,
                        input logic [N*R-1:0] d, input logic c);
        @(negedge clk);
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check("period_tick", 32'(period_tick), 32'(exp_tick));
        check("pending", 32'(pending), 32'(exp_pend));
        hi0 += int'(pwm_out[0]);
        hi1 += int'(pwm_out[1]);
        en = e; load = l; period = p; duty = d; center = c;
        if (l) $display("load  P=%0d d0=%0d d1=%0d center=%0b en=%0b t=%0t",
                        p, d[R-1:0], d[2*R-1:R], c, e, $time);
        model_edge(e, l, int'(p), d, c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic measure(input string tag, input int cycles, input int want0, input int want1);
        hi0 = 0; hi1 = 0;
        idle(cycles);
        $display("meas  %s over %0d cycles: ch0=%0d ch1=%0d", tag, cycles, hi0, hi1);
        check({tag, "_ch0_high"}, 32'(hi0), 32'(want0));
        check({tag, "_ch1_high"}, 32'(hi1), 32'(want1));
    endtask

    // Idle until the model says the counter will sit at position tgt after the next edge.
    task automatic run_until(input int tgt);
        int k;
        k = 0;
        while (m_t != tgt && k < 300) begin
            idle(1);
            k++;
        end
        check("sync_reached", 32'(k < 300), 32'd1);
    endtask

    initial begin
        logic [R-1:0]   rp;
        logic [N*R-1:0] rd;
        int             sel;

        reset_n = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0; center = 1'b0;
        model_reset();
        hi0 = 0; hi1 = 0;
        #12;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Edge mode P=10, d=3/7.
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd3}, 1'b0);
        idle(12);
        measure("edge", 20, 6, 14);

        // Center mode, same duties: high 6 and 14 per 20-cycle period.
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd3}, 1'b1);
        idle(25);
        measure("center", 40, 12, 28);

        // Back to edge, then a mid-period load followed by a load on the boundary edge.
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd3}, 1'b0);
        idle(25);
        run_until(4);
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd5}, 1'b0);
        run_until(9);
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd2}, 1'b0);
        idle(2);
        check("boundary_load_pending", 32'(pending), 32'd1);
        idle(25);
        measure("edge_d2", 20, 4, 14);

        // Extremes: d0=0 never high, d1=200 always high, both alignments.
        step(1'b1, 1'b1, 8'd10, {8'd200, 8'd0}, 1'b0);
        idle(25);
        measure("edge_ext", 20, 0, 20);
        step(1'b1, 1'b1, 8'd10, {8'd200, 8'd0}, 1'b1);
        idle(25);
        measure("center_ext", 40, 0, 40);

        // Asynchronous reset while the counter sits at 6.
        step(1'b1, 1'b1, 8'd10, {8'd7, 8'd3}, 1'b0);
        idle(25);
        run_until(6);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_tick", 32'(period_tick), 32'd0);
        check("async_rst_pending", 32'(pending), 32'd0);
        en = 1'b0; load = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset released at %0t", $time);
        idle(5);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      rp = 8'd0;
            else if (sel == 1) rp = 8'd1;
            else if (sel == 2) rp = 8'($urandom_range(13, 40));
            else               rp = 8'($urandom_range(2, 12));
            for (int i = 0; i < N; i++) begin
                sel = int'($urandom_range(0, 7));
                if (sel == 0)      rd[i*R +: R] = 8'd0;
                else if (sel == 1) rd[i*R +: R] = 8'd255;
                else               rd[i*R +: R] = 8'($urandom_range(0, int'(rp) + 2));
            end
            step(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 24) == 0),
                 rp, rd, 1'($urandom_range(0, 1)));
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
